// File: rtl/output_bank_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : output_bank_stream_scheduler
// Description : Arbitrates the shared output feature-vector SRAM banks among
//               edge-PE read requesters and write-stream requesters. Each bank
//               runs a small FSM (IDLE / OWN_WR / OWN_RD) with its own
//               round-robin pointer and watchdog. The owner's command or beats
//               are forwarded to the bank through a registered output stage.
// Ports       :
//   clk, reset            clock, synchronous active-high reset
//   req_valid/rd_wr/node  per-requester bank request (node id picks the bank)
//   beat_valid/data/eos   per-requester write beats
//   bank_rd_done          per-bank read completion
//   grant                 one-cycle grant pulse per requester
//   bank_*                per-bank command/beat outputs, owner tag, busy flag
//   timeout_err           per-bank pulse on watchdog forced release
// Revision    : 1.0 - initial release
// ============================================================================
module output_bank_stream_scheduler #(
  parameter int NUM_REQS  = 8,
  parameter int NUM_BANKS = 4,
  parameter int NODE_W    = 10,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0]             req_rd_wr,
  input  logic [NUM_REQS*NODE_W-1:0]      req_node_id,
  input  logic [NUM_REQS-1:0]             beat_valid,
  input  logic [NUM_REQS*DATA_W-1:0]      beat_data,
  input  logic [NUM_REQS-1:0]             beat_eos,
  input  logic [NUM_BANKS-1:0]            bank_rd_done,
  output logic [NUM_REQS-1:0]             grant,
  output logic [NUM_BANKS-1:0]            bank_valid,
  output logic [NUM_BANKS-1:0]            bank_rd_wr,
  output logic [NUM_BANKS*NODE_W-1:0]     bank_node_id,
  output logic [NUM_BANKS*DATA_W-1:0]     bank_data,
  output logic [NUM_BANKS-1:0]            bank_sos,
  output logic [NUM_BANKS-1:0]            bank_eos,
  output logic [NUM_BANKS*((NUM_REQS > 1) ? $clog2(NUM_REQS) : 1)-1:0] bank_owner,
  output logic [NUM_BANKS-1:0]            bank_busy,
  output logic [NUM_BANKS-1:0]            timeout_err
);

  localparam int c_OWN_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int c_IDX_W = c_OWN_W + 1;
  localparam int c_WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [NODE_W-1:0] c_BANK_MASK = NODE_W'(NUM_BANKS - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_OWN_WR = 2'd1;
  localparam logic [1:0] c_OWN_RD = 2'd2;

  // A requester that already owns some bank may not win another one.
  logic [NUM_REQS-1:0]           w_is_owner;
  logic [NUM_BANKS*NUM_REQS-1:0] w_win_flat;
  logic [NUM_REQS-1:0]           w_grant_nxt;
  logic [NUM_REQS-1:0]           r_grant;

  always_comb begin
    w_is_owner = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_busy[b]) begin
        w_is_owner[bank_owner[b*c_OWN_W +: c_OWN_W]] = 1'b1;
      end
    end
  end

  // Each requester targets exactly one bank, so per-bank winners never collide.
  always_comb begin
    w_grant_nxt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_grant_nxt = w_grant_nxt | w_win_flat[b*NUM_REQS +: NUM_REQS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
    end else begin
      r_grant <= w_grant_nxt;
    end
  end

  assign grant = r_grant;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [1:0]          r_state;
    logic [c_OWN_W-1:0]  r_owner;
    logic [c_OWN_W-1:0]  r_ptr;
    logic [NODE_W-1:0]   r_node;
    logic [c_WD_W-1:0]   r_wdog;
    logic                r_sos_pend;
    logic                r_fresh;
    logic                r_valid;
    logic                r_rd_wr;
    logic [DATA_W-1:0]   r_data;
    logic                r_sos;
    logic                r_eos;
    logic                r_tout;

    logic [NUM_REQS-1:0] w_elig;
    logic [NUM_REQS-1:0] w_win_oh;
    logic                w_found;
    logic [c_OWN_W-1:0]  w_win;
    logic                w_beat;
    logic                w_beat_eos;
    logic [DATA_W-1:0]   w_beat_data;
    logic                w_wd_hit;

    always_comb begin
      w_elig = '0;
      for (int r = 0; r < NUM_REQS; r++) begin
        w_elig[r] = req_valid[r] && !w_is_owner[r] &&
                    ((req_node_id[r*NODE_W +: NODE_W] & c_BANK_MASK) == NODE_W'(b));
      end
    end

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQS.
    always_comb begin
      logic [c_IDX_W-1:0] idx;
      idx     = '0;
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
        idx = {1'b0, r_ptr} + c_IDX_W'(k);
        if (idx >= c_IDX_W'(NUM_REQS)) begin
          idx = idx - c_IDX_W'(NUM_REQS);
        end
        if (!w_found && w_elig[idx[c_OWN_W-1:0]]) begin
          w_found = 1'b1;
          w_win   = idx[c_OWN_W-1:0];
        end
      end
    end

    always_comb begin
      w_win_oh = '0;
      if ((r_state == c_IDLE) && w_found) begin
        w_win_oh[w_win] = 1'b1;
      end
    end

    assign w_win_flat[b*NUM_REQS +: NUM_REQS] = w_win_oh;

    // Beats in the grant cycle itself are not part of the stream: the
    // requester only learns of ownership from the grant pulse.
    assign w_beat      = (r_state == c_OWN_WR) && !r_fresh && beat_valid[r_owner];
    assign w_beat_eos  = beat_eos[r_owner];
    assign w_beat_data = beat_data[int'(r_owner)*DATA_W +: DATA_W];
    assign w_wd_hit    = (r_wdog == c_WD_W'(TIMEOUT));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state    <= c_IDLE;
        r_owner    <= '0;
        r_ptr      <= '0;
        r_node     <= '0;
        r_wdog     <= '0;
        r_sos_pend <= 1'b0;
        r_fresh    <= 1'b0;
        r_valid    <= 1'b0;
        r_rd_wr    <= 1'b0;
        r_data     <= '0;
        r_sos      <= 1'b0;
        r_eos      <= 1'b0;
        r_tout     <= 1'b0;
      end else begin
        r_valid <= 1'b0;
        r_rd_wr <= 1'b0;
        r_data  <= '0;
        r_sos   <= 1'b0;
        r_eos   <= 1'b0;
        r_tout  <= 1'b0;
        r_fresh <= 1'b0;
        case (r_state)
          c_IDLE: begin
            if (w_found) begin
              r_state    <= req_rd_wr[w_win] ? c_OWN_WR : c_OWN_RD;
              r_owner    <= w_win;
              r_node     <= req_node_id[int'(w_win)*NODE_W +: NODE_W];
              r_ptr      <= (w_win == c_OWN_W'(NUM_REQS - 1)) ? '0 : w_win + 1'b1;
              r_wdog     <= '0;
              r_sos_pend <= req_rd_wr[w_win];
              r_fresh    <= 1'b1;
              // A read is a single command issued together with the grant.
              r_valid    <= !req_rd_wr[w_win];
            end
          end
          c_OWN_WR: begin
            if (w_beat) begin
              r_valid    <= 1'b1;
              r_rd_wr    <= 1'b1;
              r_data     <= w_beat_data;
              r_sos      <= r_sos_pend;
              r_sos_pend <= 1'b0;
              r_wdog     <= '0;
              if (w_beat_eos) begin
                r_eos   <= 1'b1;
                r_state <= c_IDLE;
                r_owner <= '0;
                r_node  <= '0;
              end
            end else if (w_wd_hit) begin
              // Forced release: no eos is emitted for an abandoned stream.
              r_tout     <= 1'b1;
              r_state    <= c_IDLE;
              r_owner    <= '0;
              r_node     <= '0;
              r_wdog     <= '0;
              r_sos_pend <= 1'b0;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
          end
          c_OWN_RD: begin
            if (bank_rd_done[b]) begin
              r_state <= c_IDLE;
              r_owner <= '0;
              r_node  <= '0;
              r_wdog  <= '0;
            end else if (w_wd_hit) begin
              r_tout  <= 1'b1;
              r_state <= c_IDLE;
              r_owner <= '0;
              r_node  <= '0;
              r_wdog  <= '0;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
          end
          default: begin
            r_state <= c_IDLE;
            r_owner <= '0;
            r_node  <= '0;
            r_wdog  <= '0;
          end
        endcase
      end
    end

    assign bank_valid[b]                       = r_valid;
    assign bank_rd_wr[b]                       = r_rd_wr;
    assign bank_data[b*DATA_W +: DATA_W]       = r_data;
    assign bank_sos[b]                         = r_sos;
    assign bank_eos[b]                         = r_eos;
    assign bank_node_id[b*NODE_W +: NODE_W]    = r_node;
    assign bank_owner[b*c_OWN_W +: c_OWN_W]    = r_owner;
    assign bank_busy[b]                        = (r_state != c_IDLE);
    assign timeout_err[b]                      = r_tout;
  end

endmodule
`default_nettype wire
